// File: rtl/knap_pkg.sv
// Shared definitions for the knapsack search engine.
//   state_t          - controller states (IDLE/SEARCH/CHECK/DONE)
//   MODE_SEARCH/CHECK - encodings of the mode input
//   clog2            - ceiling log2, used for index widths
//   trailing_zeros   - index of the lowest set bit (0 for a zero input)
//   acc_w_ok         - accumulator width legality for a given item count
package knap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic MODE_SEARCH = 1'b0;
    localparam logic MODE_CHECK  = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Scan downward so the lowest set bit is the last one written.
    function automatic int trailing_zeros(input logic [31:0] x);
        int r;
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) r = i;
        end
        return r;
    endfunction

    // Sums of all items must fit without wrapping.
    function automatic bit acc_w_ok(input int acc_w, input int coef_w, input int n_items);
        return (acc_w >= coef_w + clog2(n_items)) && (n_items >= 2) && (n_items <= 16);
    endfunction

endpackage

// File: rtl/knap_gray_step.sv
// Gray-code step decoder: given the next binary count k+1, reports which
// item toggles between gray(k) and gray(k+1) and whether it turns on.
//   k_next     in  N_ITEMS  binary counter value k+1 (nonzero when used)
//   toggle_idx out IDX_W    item whose mask bit changes
//   toggle_add out 1        1 = bit goes 0->1 (add coefficients), 0 = remove
module knap_gray_step
    import knap_pkg::*;
#(
    parameter int N_ITEMS = 6,
    parameter int IDX_W   = 3
) (
    input  logic [N_ITEMS-1:0] k_next,
    output logic [IDX_W-1:0]   toggle_idx,
    output logic               toggle_add
);

    int tz;

    // gray(k+1)[t] = (k+1)[t] ^ (k+1)[t+1]; with (k+1)[t] = 1 the new bit
    // is set exactly when (k+1)[t+1] is clear. Above the top item it is 0.
    always_comb begin
        tz         = trailing_zeros(32'(k_next));
        toggle_idx = IDX_W'(tz);
        toggle_add = 1'b1;
        for (int i = 0; i < N_ITEMS - 1; i++) begin
            if (tz == i) toggle_add = ~k_next[i+1];
        end
    end

endmodule

// File: rtl/knap_search_engine.sv
// Knapsack search engine. Exhaustively searches all item subsets in Gray
// order (one per clock) for the best feasible one, or checks a single mask.
//   clk, rst                         clock, async active-high reset
//   cfg_we/cfg_idx/cfg_value/...     coefficient write port (IDLE only)
//   min_value/max_weight/max_volume  limits, latched at start
//   mode, check_mask                 operation select / mask, latched at start
//   start                            launch (IDLE only)
//   busy, done                       status; done is a one-cycle pulse
//   best_valid/best_mask/best_value  result; held until next start
//   feasible_count                   number of feasible subsets seen
//
//   state  | meaning
//   IDLE   | waiting; coefficient writes and start accepted
//   SEARCH | one Gray-ordered subset evaluated per cycle
//   CHECK  | accumulating check_mask items, one per cycle
//   DONE   | done pulse, results stable, back to IDLE
module knap_search_engine
    import knap_pkg::*;
#(
    parameter int N_ITEMS = 6,
    parameter int COEF_W  = 8,
    parameter int ACC_W   = 11,
    localparam int IDX_W  = clog2(N_ITEMS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [COEF_W-1:0]  cfg_value,
    input  logic [COEF_W-1:0]  cfg_weight,
    input  logic [COEF_W-1:0]  cfg_volume,
    input  logic [ACC_W-1:0]   min_value,
    input  logic [ACC_W-1:0]   max_weight,
    input  logic [ACC_W-1:0]   max_volume,
    input  logic               mode,
    input  logic [N_ITEMS-1:0] check_mask,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               best_valid,
    output logic [N_ITEMS-1:0] best_mask,
    output logic [ACC_W-1:0]   best_value,
    output logic [N_ITEMS:0]   feasible_count
);

    if (!acc_w_ok(ACC_W, COEF_W, N_ITEMS)) begin : g_param_check
        $error("knap_search_engine: N_ITEMS out of range or ACC_W too narrow");
    end

    state_t              state;
    logic [COEF_W-1:0]   coef_val [N_ITEMS];
    logic [COEF_W-1:0]   coef_wgt [N_ITEMS];
    logic [COEF_W-1:0]   coef_vol [N_ITEMS];
    logic [ACC_W-1:0]    lim_min, lim_wgt, lim_vol;
    logic [N_ITEMS-1:0]  chk_mask, k, mask;
    logic [IDX_W-1:0]    chk_idx, toggle_idx;
    logic                toggle_add;
    logic [ACC_W-1:0]    sum_val, sum_wgt, sum_vol, best_wgt;
    logic [ACC_W-1:0]    add_val, add_wgt, add_vol, nxt_val, nxt_wgt, nxt_vol;
    logic [ACC_W-1:0]    tog_val, tog_wgt, tog_vol;
    logic                cur_feas, nxt_feas, cur_better;

    knap_gray_step #(.N_ITEMS(N_ITEMS), .IDX_W(IDX_W)) u_gray_step (
        .k_next     (k + N_ITEMS'(1)),
        .toggle_idx (toggle_idx),
        .toggle_add (toggle_add)
    );

    assign busy = (state == ST_SEARCH) || (state == ST_CHECK);
    assign done = (state == ST_DONE);

    always_comb begin
        add_val = '0;
        add_wgt = '0;
        add_vol = '0;
        if (chk_mask[chk_idx]) begin
            add_val = ACC_W'(coef_val[chk_idx]);
            add_wgt = ACC_W'(coef_wgt[chk_idx]);
            add_vol = ACC_W'(coef_vol[chk_idx]);
        end
        nxt_val = sum_val + add_val;
        nxt_wgt = sum_wgt + add_wgt;
        nxt_vol = sum_vol + add_vol;
        tog_val = ACC_W'(coef_val[toggle_idx]);
        tog_wgt = ACC_W'(coef_wgt[toggle_idx]);
        tog_vol = ACC_W'(coef_vol[toggle_idx]);
        cur_feas   = (sum_val >= lim_min) && (sum_wgt <= lim_wgt) && (sum_vol <= lim_vol);
        nxt_feas   = (nxt_val >= lim_min) && (nxt_wgt <= lim_wgt) && (nxt_vol <= lim_vol);
        // Strictly better only; ties on both value and weight keep the earlier subset.
        cur_better = !best_valid || (sum_val > best_value) ||
                     ((sum_val == best_value) && (sum_wgt < best_wgt));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                coef_val[i] <= '0;
                coef_wgt[i] <= '0;
                coef_vol[i] <= '0;
            end
        end else if (cfg_we && (state == ST_IDLE) && (int'(cfg_idx) < N_ITEMS)) begin
            coef_val[cfg_idx] <= cfg_value;
            coef_wgt[cfg_idx] <= cfg_weight;
            coef_vol[cfg_idx] <= cfg_volume;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            lim_min        <= '0;
            lim_wgt        <= '0;
            lim_vol        <= '0;
            chk_mask       <= '0;
            k              <= '0;
            mask           <= '0;
            chk_idx        <= '0;
            sum_val        <= '0;
            sum_wgt        <= '0;
            sum_vol        <= '0;
            best_wgt       <= '0;
            best_valid     <= 1'b0;
            best_mask      <= '0;
            best_value     <= '0;
            feasible_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lim_min        <= min_value;
                        lim_wgt        <= max_weight;
                        lim_vol        <= max_volume;
                        chk_mask       <= check_mask;
                        k              <= '0;
                        mask           <= '0;
                        chk_idx        <= '0;
                        sum_val        <= '0;
                        sum_wgt        <= '0;
                        sum_vol        <= '0;
                        best_wgt       <= '0;
                        best_valid     <= 1'b0;
                        best_mask      <= '0;
                        best_value     <= '0;
                        feasible_count <= '0;
                        state          <= (mode == MODE_CHECK) ? ST_CHECK : ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (cur_feas) begin
                        feasible_count <= feasible_count + (N_ITEMS+1)'(1);
                        if (cur_better) begin
                            best_valid <= 1'b1;
                            best_mask  <= mask;
                            best_value <= sum_val;
                            best_wgt   <= sum_wgt;
                        end
                    end
                    if (k == '1) begin
                        state <= ST_DONE;
                    end else begin
                        k    <= k + N_ITEMS'(1);
                        mask <= mask ^ (N_ITEMS'(1) << toggle_idx);
                        if (toggle_add) begin
                            sum_val <= sum_val + tog_val;
                            sum_wgt <= sum_wgt + tog_wgt;
                            sum_vol <= sum_vol + tog_vol;
                        end else begin
                            sum_val <= sum_val - tog_val;
                            sum_wgt <= sum_wgt - tog_wgt;
                            sum_vol <= sum_vol - tog_vol;
                        end
                    end
                end
                ST_CHECK: begin
                    sum_val <= nxt_val;
                    sum_wgt <= nxt_wgt;
                    sum_vol <= nxt_vol;
                    // Evaluation is folded into the last accumulate cycle.
                    if (chk_idx == IDX_W'(N_ITEMS - 1)) begin
                        best_mask      <= chk_mask;
                        best_value     <= nxt_val;
                        best_valid     <= nxt_feas;
                        feasible_count <= nxt_feas ? (N_ITEMS+1)'(1) : '0;
                        state          <= ST_DONE;
                    end else begin
                        chk_idx <= chk_idx + IDX_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knap_search_engine.sv
module tb_knap_search_engine;
    import knap_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // N_ITEMS = 6 instance
    logic        cfg_we = 0, mode = 0, start = 0;
    logic [2:0]  cfg_idx = 0;
    logic [7:0]  cfg_value = 0, cfg_weight = 0, cfg_volume = 0;
    logic [10:0] min_value = 0, max_weight = 0, max_volume = 0;
    logic [5:0]  check_mask = 0;
    logic        busy, done, best_valid;
    logic [5:0]  best_mask;
    logic [10:0] best_value;
    logic [6:0]  feasible_count;

    // N_ITEMS = 8 instance
    logic        e_cfg_we = 0, e_mode = 0, e_start = 0;
    logic [2:0]  e_cfg_idx = 0;
    logic [7:0]  e_cfg_value = 0, e_cfg_weight = 0, e_cfg_volume = 0;
    logic [10:0] e_min_value = 0, e_max_weight = 0, e_max_volume = 0;
    logic [7:0]  e_check_mask = 0;
    logic        e_busy, e_done, e_best_valid;
    logic [7:0]  e_best_mask;
    logic [10:0] e_best_value;
    logic [8:0]  e_feasible_count;

    knap_search_engine #(.N_ITEMS(6), .COEF_W(8), .ACC_W(11)) dut6 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_value(cfg_value), .cfg_weight(cfg_weight), .cfg_volume(cfg_volume),
        .min_value(min_value), .max_weight(max_weight), .max_volume(max_volume),
        .mode(mode), .check_mask(check_mask), .start(start),
        .busy(busy), .done(done), .best_valid(best_valid), .best_mask(best_mask),
        .best_value(best_value), .feasible_count(feasible_count)
    );

    knap_search_engine #(.N_ITEMS(8), .COEF_W(8), .ACC_W(11)) dut8 (
        .clk(clk), .rst(rst), .cfg_we(e_cfg_we), .cfg_idx(e_cfg_idx),
        .cfg_value(e_cfg_value), .cfg_weight(e_cfg_weight), .cfg_volume(e_cfg_volume),
        .min_value(e_min_value), .max_weight(e_max_weight), .max_volume(e_max_volume),
        .mode(e_mode), .check_mask(e_check_mask), .start(e_start),
        .busy(e_busy), .done(e_done), .best_valid(e_best_valid), .best_mask(e_best_mask),
        .best_value(e_best_value), .feasible_count(e_feasible_count)
    );

    int ntests = 0;
    int nfail  = 0;
    int m_v[16], m_w[16], m_c[16];
    int ev, em, eval, ecnt, cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_item(input int i, input int v, input int w, input int c);
        m_v[i] = v; m_w[i] = w; m_c[i] = c;
    endtask

    // Reference: enumerate subsets in Gray order, sum each directly.
    task automatic model_search(input int n, input int mn, input int mw, input int mc,
                                output int o_valid, output int o_mask, output int o_value,
                                output int o_count);
        int bw, g, sv, sw, sc;
        o_valid = 0; o_mask = 0; o_value = 0; o_count = 0; bw = 0;
        for (int k = 0; k < (1 << n); k++) begin
            g = k ^ (k >> 1);
            sv = 0; sw = 0; sc = 0;
            for (int i = 0; i < n; i++) begin
                if (g[i]) begin sv += m_v[i]; sw += m_w[i]; sc += m_c[i]; end
            end
            if (sv >= mn && sw <= mw && sc <= mc) begin
                o_count++;
                if (o_valid == 0 || sv > o_value || (sv == o_value && sw < bw)) begin
                    o_valid = 1; o_mask = g; o_value = sv; bw = sw;
                end
            end
        end
    endtask

    task automatic model_check(input int n, input int msk, input int mn, input int mw,
                               input int mc, output int o_valid, output int o_value);
        int sw, sc;
        o_value = 0; sw = 0; sc = 0;
        for (int i = 0; i < n; i++) begin
            if (msk[i]) begin o_value += m_v[i]; sw += m_w[i]; sc += m_c[i]; end
        end
        o_valid = (o_value >= mn && sw <= mw && sc <= mc) ? 1 : 0;
    endtask

    task automatic load6();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cfg_we = 1; cfg_idx = 3'(i);
            cfg_value = 8'(m_v[i]); cfg_weight = 8'(m_w[i]); cfg_volume = 8'(m_c[i]);
        end
        @(negedge clk); cfg_we = 0;
    endtask

    task automatic load8();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            e_cfg_we = 1; e_cfg_idx = 3'(i);
            e_cfg_value = 8'(m_v[i]); e_cfg_weight = 8'(m_w[i]); e_cfg_volume = 8'(m_c[i]);
        end
        @(negedge clk); e_cfg_we = 0;
    endtask

    // Cycle 0 is the cycle start is held high; returns the cycle done is seen.
    // At cycle 'poke' start and a coefficient write to item 1 are pulsed.
    task automatic run6(input logic md, input logic [5:0] msk, input int mn, input int mw,
                        input int mc, input int poke, output int c);
        bit got;
        @(negedge clk);
        mode = md; check_mask = msk;
        min_value = 11'(mn); max_weight = 11'(mw); max_volume = 11'(mc);
        start = 1;
        c = 0; got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            c++; start = 0; cfg_we = 0;
            if (c == 1) check("busy_after_start6", 32'(busy), 32'd1);
            if (c == poke) begin
                start = 1; cfg_we = 1; cfg_idx = 3'd1;
                cfg_value = 8'd0; cfg_weight = 8'd0; cfg_volume = 8'd0;
            end
            if (done) begin
                got = 1;
                check("busy_low_at_done6", 32'(busy), 32'd0);
            end
        end
        start = 0; cfg_we = 0;
        check("done_seen6", 32'(got), 32'd1);
        @(negedge clk);
        check("done_one_cycle6", 32'(done), 32'd0);
    endtask

    task automatic run8(input logic md, input logic [7:0] msk, input int mn, input int mw,
                        input int mc, output int c);
        bit got;
        @(negedge clk);
        e_mode = md; e_check_mask = msk;
        e_min_value = 11'(mn); e_max_weight = 11'(mw); e_max_volume = 11'(mc);
        e_start = 1;
        c = 0; got = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge clk);
            c++; e_start = 0;
            if (e_done) got = 1;
        end
        check("done_seen8", 32'(got), 32'd1);
    endtask

    task automatic check6(input string tag);
        check({tag, "_valid"}, 32'(best_valid), 32'(ev));
        check({tag, "_mask"},  32'(best_mask),  32'(em));
        check({tag, "_value"}, 32'(best_value), 32'(eval));
        check({tag, "_count"}, 32'(feasible_count), 32'(ecnt));
    endtask

    task automatic load_common();
        set_item(0, 4, 28, 27);  set_item(1, 8, 8, 27);   set_item(2, 0, 27, 4);
        set_item(3, 20, 18, 4);  set_item(4, 10, 27, 0);  set_item(5, 12, 28, 24);
        load6();
    endtask

    initial begin
        bit seen;
        // reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(best_valid), 32'd0);
        check("rst_mask", 32'(best_mask), 32'd0);
        check("rst_value", 32'(best_value), 32'd0);
        check("rst_count", 32'(feasible_count), 32'd0);
        @(negedge clk); rst = 0;

        // SEARCH on the common setup
        load_common();
        model_search(6, 40, 60, 60, ev, em, eval, ecnt);
        run6(MODE_SEARCH, 6'h00, 40, 60, 60, -1, cyc);
        check("search_latency", 32'(cyc), 32'd65);
        check6("search_common");

        // CHECK feasible and infeasible masks
        model_check(6, 'h2A, 40, 60, 60, ev, eval);
        em = 'h2A; ecnt = ev;
        run6(MODE_CHECK, 6'h2A, 40, 60, 60, -1, cyc);
        check("check_latency", 32'(cyc), 32'd7);
        check6("check_2a");
        model_check(6, 'h38, 40, 60, 60, ev, eval);
        em = 'h38; ecnt = ev;
        run6(MODE_CHECK, 6'h38, 40, 60, 60, -1, cyc);
        check6("check_38");

        // boundary limits
        model_search(6, 0, 0, 0, ev, em, eval, ecnt);
        run6(MODE_SEARCH, 6'h00, 0, 0, 0, -1, cyc);
        check6("search_zero_limits");
        model_search(6, 200, 60, 60, ev, em, eval, ecnt);
        run6(MODE_SEARCH, 6'h00, 200, 60, 60, -1, cyc);
        check6("search_min200");

        // start and cfg_we while busy are ignored
        model_search(6, 40, 60, 60, ev, em, eval, ecnt);
        run6(MODE_SEARCH, 6'h00, 40, 60, 60, 10, cyc);
        check("busy_poke_latency", 32'(cyc), 32'd65);
        check6("busy_poke");
        model_check(6, 'h2A, 40, 60, 60, ev, eval);
        em = 'h2A; ecnt = ev;
        run6(MODE_CHECK, 6'h2A, 40, 60, 60, -1, cyc);
        check6("coef_kept");

        // tie-break on weight
        set_item(0, 10, 30, 0); set_item(1, 10, 20, 0); set_item(2, 0, 1, 0);
        set_item(3, 0, 1, 0);   set_item(4, 0, 1, 0);   set_item(5, 0, 1, 0);
        load6();
        model_search(6, 10, 25, 0, ev, em, eval, ecnt);
        run6(MODE_SEARCH, 6'h00, 10, 25, 0, -1, cyc);
        check6("tie_break");

        // reset at cycle 20 of a SEARCH where every subset is feasible
        load_common();
        @(negedge clk);
        mode = MODE_SEARCH; min_value = 0; max_weight = 11'd2047; max_volume = 11'd2047;
        start = 1;
        for (int i = 0; i < 20; i++) begin @(negedge clk); start = 0; end
        check("count_before_rst", 32'(feasible_count), 32'd19);
        rst = 1; #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(best_valid), 32'd0);
        check("midrst_mask", 32'(best_mask), 32'd0);
        check("midrst_value", 32'(best_value), 32'd0);
        check("midrst_count", 32'(feasible_count), 32'd0);
        @(negedge clk); rst = 0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin @(negedge clk); if (done || busy) seen = 1; end
        check("no_done_after_rst", 32'(seen), 32'd0);
        // coefficient file was cleared by reset
        for (int i = 0; i < 6; i++) set_item(i, 0, 0, 0);
        model_check(6, 'h3F, 0, 0, 0, ev, eval);
        em = 'h3F; ecnt = ev;
        run6(MODE_CHECK, 6'h3F, 0, 0, 0, -1, cyc);
        check6("coef_after_rst");

        // random N_ITEMS = 8 against the reference model
        for (int r = 0; r < 3; r++) begin
            int mn, mw, mc, msk;
            for (int i = 0; i < 8; i++)
                set_item(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 255)));
            load8();
            mn = int'($urandom_range(0, 700));
            mw = int'($urandom_range(100, 1100));
            mc = int'($urandom_range(100, 1100));
            model_search(8, mn, mw, mc, ev, em, eval, ecnt);
            run8(MODE_SEARCH, 8'h00, mn, mw, mc, cyc);
            check("rnd_search_latency", 32'(cyc), 32'd257);
            check("rnd_search_valid", 32'(e_best_valid), 32'(ev));
            check("rnd_search_mask", 32'(e_best_mask), 32'(em));
            check("rnd_search_value", 32'(e_best_value), 32'(eval));
            check("rnd_search_count", 32'(e_feasible_count), 32'(ecnt));
            msk = int'($urandom_range(0, 255));
            model_check(8, msk, mn, mw, mc, ev, eval);
            run8(MODE_CHECK, 8'(msk), mn, mw, mc, cyc);
            check("rnd_check_latency", 32'(cyc), 32'd9);
            check("rnd_check_valid", 32'(e_best_valid), 32'(ev));
            check("rnd_check_mask", 32'(e_best_mask), 32'(msk));
            check("rnd_check_value", 32'(e_best_value), 32'(eval));
            check("rnd_check_count", 32'(e_feasible_count), 32'(ev));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
